// File: rtl/mips_bus_responder.sv
// Data-bus responder for the multi-cycle MIPS core: word RAM, LED/switch GPIO and,
// when BUS_TIMER_EN is defined, a down-counting timer that drives INT.
module mips_bus_responder #(
  parameter int RAM_AW  = 10,
  parameter int LED_W   = 16,
  parameter int SW_W    = 16,
  parameter int TIMER_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
  output logic [31:0]       Data_out,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              INT
);

  localparam logic [29:0] WA_LED     = 30'h3FFF_FF00;
  localparam logic [29:0] WA_SW      = 30'h3FFF_FF01;
  localparam logic [29:0] WA_TCTRL   = 30'h3FFF_FF04;
  localparam logic [29:0] WA_TPRESET = 30'h3FFF_FF05;
  localparam logic [29:0] WA_TCOUNT  = 30'h3FFF_FF06;

  logic [29:0]        waddr_s;
  logic               ram_sel_s;
  logic [RAM_AW-1:0]  ram_idx_s;
  logic [31:0]        ram_rd_s;
  logic [31:0]        rd_s;
  logic [31:0]        data_out_r;
  logic [LED_W-1:0]   led_r;
  logic [SW_W-1:0]    sw_meta_r;
  logic [SW_W-1:0]    sw_sync_r;
  logic               unused_s;
  logic [31:0]        ram_r [0:(1<<RAM_AW)-1];

  assign waddr_s   = Addr_in[31:2];
  assign ram_sel_s = (Addr_in[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
  assign ram_idx_s = Addr_in[RAM_AW+1:2];
  assign ram_rd_s  = ram_r[ram_idx_s];
  assign unused_s  = ^Addr_in[1:0];

  // Word RAM write port; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_w && ram_sel_s) begin
      ram_r[ram_idx_s] <= Data_in;
    end
  end

  // Two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_r <= {SW_W{1'b0}};
      sw_sync_r <= {SW_W{1'b0}};
    end else begin
      sw_meta_r <= sw_in;
      sw_sync_r <= sw_meta_r;
    end
  end

  // LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= {LED_W{1'b0}};
    end else if (mem_w && !ram_sel_s && (waddr_s == WA_LED)) begin
      led_r <= Data_in[LED_W-1:0];
    end
  end

`ifdef BUS_TIMER_EN
  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_LOAD   = 2'd1,
    T_COUNT  = 2'd2,
    T_EXPIRE = 2'd3
  } tstate_e;

  localparam logic [TIMER_W-1:0] CNT_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  tstate_e             state_r;
  tstate_e             state_nxt_s;
  logic [TIMER_W-1:0]  preset_r;
  logic [TIMER_W-1:0]  count_r;
  logic [TIMER_W-1:0]  count_nxt_s;
  logic                en_r;
  logic                auto_r;
  logic                msk_r;
  logic                irq_r;
  logic                int_r;
  logic                tctrl_wr_s;
  logic                tpreset_wr_s;
  logic                en_next_s;
  logic                irq_set_s;
  logic                en_clr_s;

  assign tctrl_wr_s   = mem_w && !ram_sel_s && (waddr_s == WA_TCTRL);
  assign tpreset_wr_s = mem_w && !ram_sel_s && (waddr_s == WA_TPRESET);
  // A disabling TCTRL write takes effect on its own edge so the count never moves after it
  assign en_next_s    = tctrl_wr_s ? Data_in[0] : en_r;

  // Timer next-state and count logic
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    irq_set_s   = 1'b0;
    en_clr_s    = 1'b0;
    case (state_r)
      T_IDLE: begin
        if (en_r) begin
          state_nxt_s = T_LOAD;
        end else begin
          state_nxt_s = T_IDLE;
        end
      end
      T_LOAD: begin
        count_nxt_s = preset_r;
        state_nxt_s = T_COUNT;
      end
      T_COUNT: begin
        if (!en_next_s) begin
          state_nxt_s = T_IDLE;
        end else if (tpreset_wr_s) begin
          state_nxt_s = T_LOAD;
        end else if (count_r <= CNT_ONE) begin
          count_nxt_s = {TIMER_W{1'b0}};
          irq_set_s   = 1'b1;
          state_nxt_s = T_EXPIRE;
        end else begin
          count_nxt_s = count_r - CNT_ONE;
        end
      end
      T_EXPIRE: begin
        if (auto_r) begin
          state_nxt_s = T_LOAD;
        end else begin
          en_clr_s    = 1'b1;
          state_nxt_s = T_IDLE;
        end
      end
      default: begin
        state_nxt_s = T_IDLE;
      end
    endcase
  end

  // Timer state, control/status registers and registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= T_IDLE;
      count_r  <= {TIMER_W{1'b0}};
      preset_r <= {TIMER_W{1'b0}};
      en_r     <= 1'b0;
      auto_r   <= 1'b0;
      msk_r    <= 1'b0;
      irq_r    <= 1'b0;
      int_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      int_r   <= irq_r & msk_r;
      if (tctrl_wr_s) begin
        en_r   <= Data_in[0];
        auto_r <= Data_in[1];
        msk_r  <= Data_in[3];
      end else if (en_clr_s) begin
        en_r <= 1'b0;
      end
      // Expiry setting the status beats a simultaneous write-1-to-clear
      if (irq_set_s) begin
        irq_r <= 1'b1;
      end else if (tctrl_wr_s && Data_in[31]) begin
        irq_r <= 1'b0;
      end
      if (tpreset_wr_s) begin
        preset_r <= Data_in[TIMER_W-1:0];
      end
    end
  end

  assign INT = int_r;
`else
  logic [TIMER_W-1:0] unused_timer_s;
  assign unused_timer_s = {TIMER_W{1'b0}};
  assign INT = 1'b0;
`endif

  // Read-data decode
  always_comb begin
    rd_s = 32'd0;
    if (ram_sel_s) begin
      rd_s = ram_rd_s;
    end else begin
      case (waddr_s)
        WA_LED:     rd_s[LED_W-1:0] = led_r;
        WA_SW:      rd_s[SW_W-1:0]  = sw_sync_r;
`ifdef BUS_TIMER_EN
        WA_TCTRL:   rd_s = {irq_r, 27'd0, msk_r, 1'b0, auto_r, en_r};
        WA_TPRESET: rd_s[TIMER_W-1:0] = preset_r;
        WA_TCOUNT:  rd_s[TIMER_W-1:0] = count_r;
`endif
        default:    rd_s = 32'd0;
      endcase
    end
  end

  // Registered read data, held during store cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= 32'd0;
    end else if (!mem_w) begin
      data_out_r <= rd_s;
    end
  end

  assign Data_out = data_out_r;
  assign led_out  = led_r;

endmodule

// File: tb/tb_mips_bus_responder.sv
// Self-checking bench for mips_bus_responder: random bus traffic scored against a
// transaction-level model of RAM, GPIO and timer (timer expectations follow BUS_TIMER_EN).
module tb_mips_bus_responder;

  localparam logic [31:0] A_LED   = 32'hFFFF_FC00;
  localparam logic [31:0] A_SW    = 32'hFFFF_FC04;
  localparam logic [31:0] A_TCTRL = 32'hFFFF_FC10;
  localparam logic [31:0] A_TPRE  = 32'hFFFF_FC14;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_FC18;
  localparam logic [31:0] A_UNM   = 32'h8000_0000;
`ifdef BUS_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] Addr_in = 32'd0;
  logic [31:0] Data_in = 32'd0;
  logic [15:0] sw_in = 16'd0;
  logic [31:0] Data_out;
  logic [15:0] led_out;
  logic        INT;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  bit [31:0] m_ram [int];
  bit [15:0] m_led, m_sw1, m_sw2;
  bit [31:0] m_preset, m_cnt;
  bit        m_en, m_auto, m_msk, m_irq;
  int        m_ph;          // 0 idle, 1 load, 2 count, 3 expired
  bit [31:0] exp_dout;
  bit [15:0] exp_led;
  bit        exp_int;

  mips_bus_responder dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .Addr_in(Addr_in), .Data_in(Data_in),
    .Data_out(Data_out), .sw_in(sw_in), .led_out(led_out), .INT(INT)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_edge(input bit w, input bit [31:0] a, input bit [31:0] d);
    bit [31:0] wa, rd;
    bit tw, pw, en_next, irq_set, en_clr, new_int;
    wa = {a[31:2], 2'b00};
    if (rst) begin
      m_led = 0; m_sw1 = 0; m_sw2 = 0; m_preset = 0; m_cnt = 0;
      m_en = 0; m_auto = 0; m_msk = 0; m_irq = 0; m_ph = 0;
      exp_dout = 0; exp_int = 0; exp_led = 0;
      return;
    end
    rd = 0;
    if (wa < 32'd4096) rd = m_ram.exists(wa / 4) ? m_ram[wa / 4] : 32'd0;
    else if (wa == A_LED) rd = {16'h0, m_led};
    else if (wa == A_SW) rd = {16'h0, m_sw2};
    else if (TEN && wa == A_TCTRL) rd = {m_irq, 27'd0, m_msk, 1'b0, m_auto, m_en};
    else if (TEN && wa == A_TPRE) rd = m_preset;
    else if (TEN && wa == A_TCNT) rd = m_cnt;
    new_int = TEN && m_irq && m_msk;
    tw = w && wa == A_TCTRL;
    pw = w && wa == A_TPRE;
    irq_set = 0; en_clr = 0;
    if (TEN) begin
      en_next = tw ? d[0] : m_en;
      if (m_ph == 0) begin
        if (m_en) m_ph = 1;
      end else if (m_ph == 1) begin
        m_cnt = m_preset; m_ph = 2;
      end else if (m_ph == 2) begin
        if (!en_next) m_ph = 0;
        else if (pw) m_ph = 1;
        else if (m_cnt <= 1) begin m_cnt = 0; irq_set = 1; m_ph = 3; end
        else m_cnt = m_cnt - 1;
      end else begin
        if (m_auto) m_ph = 1;
        else begin en_clr = 1; m_ph = 0; end
      end
      if (tw) begin m_en = d[0]; m_auto = d[1]; m_msk = d[3]; end
      else if (en_clr) m_en = 0;
      if (irq_set) m_irq = 1;
      else if (tw && d[31]) m_irq = 0;
      if (pw) m_preset = d;
    end
    if (w && wa < 32'd4096) m_ram[wa / 4] = d;
    if (w && wa == A_LED) m_led = d[15:0];
    m_sw2 = m_sw1; m_sw1 = sw_in;
    exp_int = new_int;
    exp_led = m_led;
    if (!w) exp_dout = rd;
  endtask

  task automatic bus(input bit w, input bit [31:0] a, input bit [31:0] d);
    mem_w = w; Addr_in = a; Data_in = d;
    @(posedge clk);
    model_edge(w, a, d);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus(0, A_UNM, 0);
    bus(0, A_UNM, 0);
    rst = 1'b0;
    total_cnt++; if (Data_out !== 32'd0) $display("FAIL reset_dout got=%h want=0", Data_out); else pass_cnt++;
    total_cnt++; if (led_out !== 16'd0) $display("FAIL reset_led got=%h want=0", led_out); else pass_cnt++;
    total_cnt++; if (INT !== 1'b0) $display("FAIL reset_int got=%b want=0", INT); else pass_cnt++;
  endtask

  task automatic test_ram;
    bit [31:0] addr_q[$];
    bit [31:0] a;
    bus(1, 32'h10, 32'hDEADBEEF);
    bus(0, 32'h10, 0);
    total_cnt++; if (Data_out !== 32'hDEADBEEF) $display("FAIL ram_first got=%h want=deadbeef", Data_out); else pass_cnt++;
    bus(1, 32'h14, 32'h0);
    total_cnt++; if (Data_out !== exp_dout) $display("FAIL ram_hold_on_write got=%h want=%h", Data_out, exp_dout); else pass_cnt++;
    bus(0, 32'h14, 0);
    total_cnt++; if (Data_out !== 32'd0) $display("FAIL ram_zero got=%h want=0", Data_out); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 1023) * 4) | $urandom_range(0, 3);
      addr_q.push_back(a);
      bus(1, a, $urandom);
      bus(0, a, 0);
      total_cnt++; if (Data_out !== exp_dout) $display("FAIL ram_wr_rd a=%h got=%h want=%h", a, Data_out, exp_dout); else pass_cnt++;
    end
    for (int i = 7; i >= 0; i--) begin
      a = {addr_q[i][31:2], 2'(i)};
      bus(0, a, 0);
      total_cnt++; if (Data_out !== exp_dout) $display("FAIL ram_readback a=%h got=%h want=%h", a, Data_out, exp_dout); else pass_cnt++;
    end
  endtask

  task automatic test_gpio;
    bus(1, A_LED, 32'hFFFF_00A5);
    total_cnt++; if (led_out !== 16'h00A5) $display("FAIL led_a5 got=%h want=00a5", led_out); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      bus(1, A_LED, $urandom);
      total_cnt++; if (led_out !== exp_led) $display("FAIL led_rand got=%h want=%h", led_out, exp_led); else pass_cnt++;
      bus(0, A_LED, 0);
      total_cnt++; if (Data_out !== exp_dout) $display("FAIL led_read got=%h want=%h", Data_out, exp_dout); else pass_cnt++;
    end
    sw_in = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      bus(0, A_SW, 0);
      total_cnt++; if (Data_out !== exp_dout) $display("FAIL sw_sync cyc=%0d got=%h want=%h", i, Data_out, exp_dout); else pass_cnt++;
    end
    total_cnt++; if (Data_out !== 32'h0000_1234) $display("FAIL sw_1234 got=%h want=00001234", Data_out); else pass_cnt++;
  endtask

  task automatic test_timer_oneshot;
    bus(1, A_TPRE, 32'd3);
    bus(1, A_TCTRL, 32'h9);
    for (int i = 0; i < 10; i++) begin
      bus(0, A_TCNT, 0);
      total_cnt++; if (Data_out !== exp_dout || INT !== exp_int)
        $display("FAIL oneshot_cnt cyc=%0d got=%h/%b want=%h/%b", i, Data_out, INT, exp_dout, exp_int); else pass_cnt++;
    end
    bus(0, A_TCTRL, 0);
    total_cnt++; if (Data_out !== (TEN ? 32'h8000_0008 : 32'h0))
      $display("FAIL oneshot_ctrl got=%h want=%h", Data_out, TEN ? 32'h8000_0008 : 32'h0); else pass_cnt++;
    total_cnt++; if (INT !== TEN) $display("FAIL oneshot_int got=%b want=%b", INT, TEN); else pass_cnt++;
    bus(1, A_TCTRL, 32'h8000_0008);
    bus(0, A_TCTRL, 0);
    total_cnt++; if (INT !== 1'b0) $display("FAIL irq_clear_int got=%b want=0", INT); else pass_cnt++;
    total_cnt++; if (Data_out !== (TEN ? 32'h8 : 32'h0)) $display("FAIL irq_clear_ctrl got=%h want=%h", Data_out, TEN ? 32'h8 : 32'h0); else pass_cnt++;
  endtask

  task automatic test_timer_auto;
    int n2;
    bus(1, A_TPRE, 32'd2);
    bus(1, A_TCTRL, 32'hB);
    for (int i = 0; i < 4; i++) bus(0, A_TCNT, 0);
    n2 = 0;
    for (int i = 0; i < 16; i++) begin
      bus(0, A_TCNT, 0);
      if (Data_out == 32'd2) n2++;
      total_cnt++; if (Data_out !== exp_dout) $display("FAIL auto_cnt cyc=%0d got=%h want=%h", i, Data_out, exp_dout); else pass_cnt++;
    end
    total_cnt++; if (n2 !== (TEN ? 4 : 0)) $display("FAIL auto_period reloads=%0d want=%0d", n2, TEN ? 4 : 0); else pass_cnt++;
    bus(0, A_TCNT, 0);
    bus(0, A_TCNT, 0);
    bus(1, A_TCTRL, 32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      bus(0, A_TCNT, 0);
      total_cnt++; if (Data_out !== (TEN ? 32'd2 : 32'd0) || Data_out !== exp_dout)
        $display("FAIL auto_frozen cyc=%0d got=%h want=%h", i, Data_out, exp_dout); else pass_cnt++;
    end
    bus(0, A_TCTRL, 0);
    total_cnt++; if (Data_out !== 32'd0 || INT !== 1'b0) $display("FAIL auto_no_irq got=%h/%b want=0/0", Data_out, INT); else pass_cnt++;
  endtask

  task automatic test_timer_edges;
    // preset 0 expires one clock after the load
    bus(1, A_TPRE, 32'd0);
    bus(1, A_TCTRL, 32'h9);
    bus(0, A_TCTRL, 0); bus(0, A_TCTRL, 0); bus(0, A_TCTRL, 0);
    total_cnt++; if (Data_out[31] !== 1'b0) $display("FAIL preset0_early got=%b want=0", Data_out[31]); else pass_cnt++;
    bus(0, A_TCTRL, 0);
    total_cnt++; if (Data_out[31] !== TEN) $display("FAIL preset0_expire got=%b want=%b", Data_out[31], TEN); else pass_cnt++;
    // clear on the same edge as expiry: set wins
    bus(1, A_TCTRL, 32'h8000_0000);
    bus(1, A_TPRE, 32'd1);
    bus(1, A_TCTRL, 32'h9);
    bus(0, A_TCTRL, 0); bus(0, A_TCTRL, 0);
    bus(1, A_TCTRL, 32'h8000_0009);
    bus(0, A_TCTRL, 0);
    total_cnt++; if (Data_out !== (TEN ? 32'h8000_0009 : 32'h0) || Data_out !== exp_dout)
      $display("FAIL set_wins got=%h want=%h", Data_out, exp_dout); else pass_cnt++;
    // preset rewrite mid-count restarts
    bus(1, A_TCTRL, 32'h8000_0000);
    bus(1, A_TPRE, 32'd6);
    bus(1, A_TCTRL, 32'h1);
    bus(0, A_TCNT, 0); bus(0, A_TCNT, 0); bus(0, A_TCNT, 0);
    bus(1, A_TPRE, 32'd5);
    for (int i = 0; i < 6; i++) begin
      bus(0, A_TCNT, 0);
      total_cnt++; if (Data_out !== exp_dout) $display("FAIL restart cyc=%0d got=%h want=%h", i, Data_out, exp_dout); else pass_cnt++;
    end
    // reset mid-count
    rst = 1'b1;
    bus(0, A_TCNT, 0);
    rst = 1'b0;
    bus(0, A_TCNT, 0);
    total_cnt++; if (Data_out !== 32'd0) $display("FAIL rst_count got=%h want=0", Data_out); else pass_cnt++;
    bus(0, A_TCTRL, 0);
    total_cnt++; if (Data_out !== 32'd0) $display("FAIL rst_ctrl got=%h want=0", Data_out); else pass_cnt++;
  endtask

  task automatic test_unmapped;
    bus(1, A_LED, 32'h5A5A);
    bus(1, A_UNM, $urandom);
    bus(0, A_UNM, 0);
    total_cnt++; if (Data_out !== 32'd0) $display("FAIL unmapped_read got=%h want=0", Data_out); else pass_cnt++;
    total_cnt++; if (led_out !== 16'h5A5A) $display("FAIL unmapped_led got=%h want=5a5a", led_out); else pass_cnt++;
    bus(0, 32'h10, 0);
    total_cnt++; if (Data_out !== exp_dout) $display("FAIL unmapped_ram got=%h want=%h", Data_out, exp_dout); else pass_cnt++;
  endtask

  task automatic test_random;
    bit [31:0] a, d;
    bit w;
    int op;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 7);
      w = $urandom_range(0, 2) == 0;
      d = $urandom;
      case (op)
        0: a = A_TCTRL;
        1: begin a = A_TPRE; d = $urandom_range(0, 5); end
        2, 3: a = A_TCNT;
        4: a = A_LED;
        5: a = A_SW;
        6: a = 32'h10;
        default: begin a = A_TCTRL; w = 1'b0; end
      endcase
      if (op == 0 && w) d = {d[31], 27'd0, d[3:0]} | 32'h1;
      if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
      bus(w, a, d);
      total_cnt++; if (Data_out !== exp_dout || INT !== exp_int || led_out !== exp_led)
        $display("FAIL random cyc=%0d a=%h got=%h/%b/%h want=%h/%b/%h", i, a, Data_out, INT, led_out, exp_dout, exp_int, exp_led);
      else pass_cnt++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_ram();
    test_gpio();
    test_timer_oneshot();
    test_timer_auto();
    test_timer_edges();
    test_unmapped();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
